// File: rtl/uart_program_loader.sv
// uart_program_loader
// Serial boot loader. Takes bytes from the UART receiver and builds 32-bit
// little-endian instruction words from them. Each finished word is written
// through the program-memory write port. The core is held in reset until a
// complete, valid image has been written.
//
// Frame: 0xA5, word count N, 4*N payload bytes (LSB first, word 0 first),
//        plus one checksum byte when LOADER_CHECKSUM_EN is defined.
//
// Optional feature macro: LOADER_CHECKSUM_EN
//   When defined, a CHECK state and an 8-bit wrap-around payload checksum
//   are included. When undefined, the loader goes straight to DONE after
//   the last word write.
//
// Ports:
//   clk, reset (async, active-low)
//   rx_data / rx_valid / rx_parity_error : UART RX byte, level IRQ and parity flag
//   clear_rx                             : one-cycle pulse that clears the RX IRQ
//   prog_we / prog_addr / prog_wdata     : program memory write port
//   core_reset_n                         : core reset, held low until the image is loaded
//   load_done / load_error               : loader status
module uart_program_loader #(
   parameter int unsigned ADDR_WIDTH = 6,
   parameter int unsigned MAX_WORDS  = 64
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [7:0]            rx_data,
   input  logic                  rx_valid,
   input  logic                  rx_parity_error,
   output logic                  clear_rx,
   output logic                  prog_we,
   output logic [ADDR_WIDTH-1:0] prog_addr,
   output logic [31:0]           prog_wdata,
   output logic                  core_reset_n,
   output logic                  load_done,
   output logic                  load_error
);

   localparam int unsigned CNT_W     = 8;
   localparam logic [7:0]  SYNC_BYTE = 8'hA5;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_COUNT,
      ST_DATA,
`ifdef LOADER_CHECKSUM_EN
      ST_CHECK,
`endif
      ST_DONE,
      ST_ERROR
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] n_words;
   logic [CNT_W-1:0] word_idx;
   logic [1:0]       byte_idx;
   logic [23:0]      asm_word;   // bytes 0..2 of the word; byte 3 goes straight to prog_wdata
`ifdef LOADER_CHECKSUM_EN
   logic [7:0]       csum;
`endif
   logic             consume_c;

   // A byte is taken only when the IRQ is up, not in the clear cycle, and not in DONE
   assign consume_c = rx_valid & ~clear_rx & (state != ST_DONE);

   // Loader FSM with registered outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= ST_IDLE;
         n_words      <= '0;
         word_idx     <= '0;
         byte_idx     <= '0;
         asm_word     <= '0;
`ifdef LOADER_CHECKSUM_EN
         csum         <= '0;
`endif
         clear_rx     <= 1'b0;
         prog_we      <= 1'b0;
         prog_addr    <= '0;
         prog_wdata   <= '0;
         core_reset_n <= 1'b0;
         load_done    <= 1'b0;
         load_error   <= 1'b0;
      end else begin
         clear_rx <= consume_c;
         prog_we  <= 1'b0;

         case (state)
            ST_IDLE: begin
               if (consume_c && rx_data == SYNC_BYTE) begin
                  state <= ST_COUNT;
               end
            end

            ST_COUNT: begin
               if (consume_c) begin
                  if (rx_parity_error || rx_data == 8'd0 || 32'(rx_data) > MAX_WORDS) begin
                     state      <= ST_ERROR;
                     load_error <= 1'b1;
                  end else begin
                     n_words  <= rx_data;
                     word_idx <= '0;
                     byte_idx <= '0;
`ifdef LOADER_CHECKSUM_EN
                     csum     <= '0;
`endif
                     state    <= ST_DATA;
                  end
               end
            end

            ST_DATA: begin
               if (consume_c) begin
                  if (rx_parity_error) begin
                     // Partial word is dropped; earlier words stay in memory
                     state      <= ST_ERROR;
                     load_error <= 1'b1;
                  end else begin
`ifdef LOADER_CHECKSUM_EN
                     csum <= csum + rx_data;
`endif
                     byte_idx <= byte_idx + 2'd1;
                     case (byte_idx)
                        2'd0: asm_word[7:0]   <= rx_data;
                        2'd1: asm_word[15:8]  <= rx_data;
                        2'd2: asm_word[23:16] <= rx_data;
                        default: begin
                           prog_we    <= 1'b1;
                           prog_addr  <= ADDR_WIDTH'(word_idx);
                           prog_wdata <= {rx_data, asm_word};
                           word_idx   <= word_idx + CNT_W'(1);
                           if (word_idx == n_words - CNT_W'(1)) begin
`ifdef LOADER_CHECKSUM_EN
                              state <= ST_CHECK;
`else
                              state <= ST_DONE;
`endif
                           end
                        end
                     endcase
                  end
               end
            end

`ifdef LOADER_CHECKSUM_EN
            ST_CHECK: begin
               if (consume_c) begin
                  if (!rx_parity_error && rx_data == csum) begin
                     state        <= ST_DONE;
                     load_done    <= 1'b1;
                     core_reset_n <= 1'b1;
                  end else begin
                     state      <= ST_ERROR;
                     load_error <= 1'b1;
                  end
               end
            end
`endif

            ST_DONE: begin
               // Terminal until reset; the UART is left to software
               load_done    <= 1'b1;
               core_reset_n <= 1'b1;
            end

            ST_ERROR: begin
               // A new sync byte starts a retry from address 0
               if (consume_c && rx_data == SYNC_BYTE) begin
                  load_error <= 1'b0;
                  state      <= ST_COUNT;
               end
            end

            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: doc/uart_program_loader.md
# uart_program_loader

Serial boot loader for the single-cycle RISC-V system. It takes bytes from the existing UART receiver (received data plus the RX-interrupt flag), assembles them into 32-bit little-endian instruction words, and writes them into program memory through a dedicated write port. This is the writer side of the program memory, which the core only reads. The core is held in reset until a complete, valid image has been written.

## Interface
Parameters:
- `ADDR_WIDTH`, default 6: word-address width of the program memory write port (64 words).
- `MAX_WORDS`, default 64: largest word count accepted.

Ports:
- `clk`, input, 1: system clock.
- `reset`, input, 1: asynchronous, active-low reset.
- `rx_data`, input, 8: UART received byte.
- `rx_valid`, input, 1: UART RX interrupt. Level signal; stays high until cleared.
- `rx_parity_error`, input, 1: parity error flag for the current byte.
- `clear_rx`, output, 1: one-cycle pulse that clears the UART RX interrupt.
- `prog_we`, output, 1: program memory write strobe.
- `prog_addr`, output, `ADDR_WIDTH`: word address.
- `prog_wdata`, output, 32: instruction word.
- `core_reset_n`, output, 1: active-low reset to the core. Low while loading.
- `load_done`, output, 1: image loaded; the core is released.
- `load_error`, output, 1: protocol, parity, range or checksum error.

## Operation
- Frame format: sync `0xA5`, then word count N (1 byte), then 4·N payload bytes, least significant byte first, word 0 first. With `LOADER_CHECKSUM_EN`, one checksum byte follows the payload.
- Byte consume rule: a byte is consumed when `rx_valid`=1 is sampled while `clear_rx`=0 and the FSM is in a receiving state. `clear_rx` pulses in the next cycle. The cycle in which `clear_rx` is high never consumes a byte.
- State IDLE:
  - Non-`0xA5` bytes are consumed and discarded, parity errors ignored.
  - `0xA5` → COUNT.
- State COUNT:
  - Parity error, N=0, or N>`MAX_WORDS` → ERROR.
  - Otherwise latch N, clear the byte and word counters, clear the checksum accumulator → DATA.
- State DATA:
  - Byte `i` (0..3) of the current word is placed in bits [8i+7:8i] of the assembly register.
  - After byte 3: `prog_we` pulse, `prog_addr` = word index, `prog_wdata` = assembled word. The word index then increments.
  - Parity error on any payload byte → ERROR. No write is issued for that partial word.
  - After word N−1: → CHECK if the macro is defined, otherwise → DONE.
- State DONE:
  - `core_reset_n`=1 and `load_done`=1.
  - `rx_valid` is not consumed, so the UART is left to software.
- State ERROR:
  - `load_error`=1 and `core_reset_n`=0.
  - Bytes are consumed. `0xA5` clears `load_error` → COUNT (retry). Other bytes are discarded.
- Words already written before an error stay in memory. A retry overwrites them from address 0.

## Timing
- Reset values: `clear_rx`=0, `prog_we`=0, `prog_addr`=0, `prog_wdata`=0, `core_reset_n`=0, `load_done`=0, `load_error`=0, state IDLE.
- All outputs are registered. Byte consumed in cycle k:
  - `clear_rx` high in cycle k+1 only.
  - If it is byte 3 of a word, `prog_we` is high in cycle k+1 only, and `prog_addr`/`prog_wdata` are valid in the same cycle.
- Minimum spacing between consumed bytes is 2 cycles, forced by the clear cycle.
- Without the macro: last payload byte consumed in cycle k gives `load_done`=`core_reset_n`=1 from cycle k+2.
- With the macro: checksum byte consumed in cycle k gives DONE outputs, or `load_error`, from cycle k+1.
- `prog_addr` and `prog_wdata` hold their last values while `prog_we`=0.
- Reset asserted mid-load: all outputs return to reset values immediately and the FSM returns to IDLE. The partial image is abandoned.

## Configuration
- `LOADER_CHECKSUM_EN` defined:
  - The CHECK state is present.
  - The accumulator holds the 8-bit wrap-around sum of the 4·N payload bytes.
  - Received checksum equal to the accumulator → DONE. Mismatch or parity error → ERROR.
- Not defined:
  - No CHECK state and no accumulator.
  - The FSM goes to DONE directly after the last word write.

## Test plan
- Frame `A5 01 13 00 00 00`, bytes spaced 3 cycles apart → single `prog_we` pulse with addr 0, data `0x00000013`; `load_done`=1 and `core_reset_n`=1 two cycles after the last byte; six `clear_rx` pulses.
- Garbage `00 FF` before `A5 02` followed by 8 bytes → garbage discarded; writes to addr 0 and 1 with correctly ordered little-endian words; no error.
- Count byte `00`, then count `0x41` with `MAX_WORDS`=64 → `load_error`=1, `core_reset_n` stays 0; a following valid frame recovers to `load_done`=1.
- Parity error on payload byte 2 of word 1 → word 0 written, no write for word 1, `load_error`=1.
- `LOADER_CHECKSUM_EN` with payload `13 00 00 00` and checksum `13` → DONE; the same payload with checksum `14` → ERROR.
- `reset` driven low during word 3 of an 8-word load → outputs return to reset values at once; a full reload completes normally.
